conv_bias_act: RTL and testbench
================================

CONV_BIAS_ACT -- requirements
Module: conv_bias_act

Interface
REQ-001 SHALL have parameter CH, default 32: output channels per layer.
REQ-002 SHALL have parameter POS, default 4: spatial positions per channel per psum batch.
REQ-003 SHALL have parameter PSUM_W, default 32: signed psum width.
REQ-004 SHALL have parameter BIAS_W, default 16: signed bias width.
REQ-005 SHALL have parameter SHIFT, default 8: requantization arithmetic right-shift amount.
REQ-006 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1: synchronous active-high reset; 1 = reset, sampled on clk only.
REQ-008 SHALL have port in_valid  input  1: one-cycle pulse; psum batch and bias valid (driven by psum buffer r_en).
REQ-009 SHALL have port output_conv  input  POS*CH*PSUM_W: element (p,c) at bits [(c*POS+p)*PSUM_W +: PSUM_W].
REQ-010 SHALL have port conv_bias  input  CH*BIAS_W: bias c at [c*BIAS_W +: BIAS_W].
REQ-011 SHALL have port out_ready  input  1: downstream accepts current beat.
REQ-012 SHALL have port out_valid  output  1: out_data valid.
REQ-013 SHALL have port out_data  output  POS*8: position p at [p*8 +: 8], one channel per beat.
REQ-014 SHALL have port out_ch  output  $clog2(CH): channel index of current beat.
REQ-015 SHALL have port layer_done  output  1: one-cycle pulse on final beat handshake.
REQ-016 SHALL have port busy  output  1: high in RUN.
REQ-017 SHALL have port overflow  output  1: sticky; in_valid arrived while busy and was dropped.

Function
REQ-018 SHALL implement FSM states IDLE and RUN.
REQ-019 SHALL, in IDLE on in_valid=1, register output_conv and conv_bias, set channel counter to 0, and enter RUN.
REQ-020 SHALL assert out_valid the cycle after capture (latency 1), with out_ch=0.
REQ-021 SHALL compute per position: sum = psum + sign-extended bias at PSUM_W+1 bits; q = sum >>> SHIFT (floor, arithmetic).
REQ-022 SHALL produce output from q per Configuration, saturated to 8 bits, never wrapped.
REQ-023 SHALL hold out_data and out_ch stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, on handshake (out_valid & out_ready) with counter < CH-1, increment the counter, giving one beat per cycle under continuous ready.
REQ-025 SHALL, on handshake with counter = CH-1, pulse layer_done for that cycle and return to IDLE with out_valid=0 next cycle.
REQ-026 SHALL, when in_valid=1 coincides with final handshake, accept the new batch, stay in RUN, restart at channel 0 with no bubble, and still pulse layer_done.
REQ-027 SHALL, on in_valid=1 in RUN other than REQ-026, ignore the data, leave the current batch intact, and set overflow.

Reset
REQ-028 SHALL, while rst_n=1 at a clock edge, force IDLE, counter 0, out_valid 0, out_data 0, out_ch 0, layer_done 0, busy 0, overflow 0, regardless of state.
REQ-029 SHALL discard an in-progress batch on reset mid-RUN, with no layer_done.

Configuration
REQ-030 SHALL, with CONV_BIAS_ACT_RELU_EN defined, clamp q<0 to 0 and q>127 to 127 (ReLU, output 0..127).
REQ-031 SHALL, without CONV_BIAS_ACT_RELU_EN, saturate q to signed range -128..127, two's complement output.

Verification
REQ-032 SHALL cover: psum(0,0)=4096, bias0=256, ready=1 -> beat 0 byte 0 = 17 one cycle after in_valid; 32 beats; layer_done on beat 31.
REQ-033 SHALL cover: psum=-5000, bias=0 -> 0x00 with RELU_EN; 0xEC (-20) without.
REQ-034 SHALL cover: psum=100000, bias=-32768 -> 127; psum=-100000 without RELU_EN -> 0x80.
REQ-035 SHALL cover: out_ready low 3 cycles at out_ch=5 -> data and out_ch held, no beat skipped or repeated, 32 beats total.
REQ-036 SHALL cover: in_valid at out_ch=10 -> overflow=1, beats 11..31 from original data; in_valid on final handshake -> next cycle out_ch=0 of new batch.
REQ-037 SHALL cover: rst_n=1 one cycle at out_ch=7 -> next cycle all outputs 0 and IDLE; fresh in_valid restarts at ch 0.

Source files
------------

// File: rtl/conv_bias_act.sv
// conv_bias_act: adds a per-channel bias to a batch of convolution partial sums,
// requantizes with an arithmetic right shift and streams one channel per beat
// (POS saturated bytes per beat) over a valid/ready handshake.
// Optional build macro: CONV_BIAS_ACT_RELU_EN selects ReLU clamping (0..127);
// without it the output is saturated to signed -128..127.
// Note: rst_n is an active-high synchronous reset despite its name.
module conv_bias_act #(
    parameter int CH     = 32,
    parameter int POS    = 4,
    parameter int PSUM_W = 32,
    parameter int BIAS_W = 16,
    parameter int SHIFT  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [POS*CH*PSUM_W-1:0]   output_conv,
    input  logic [CH*BIAS_W-1:0]       conv_bias,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [POS*8-1:0]           out_data,
    output logic [$clog2(CH)-1:0]      out_ch,
    output logic                       layer_done,
    output logic                       busy,
    output logic                       overflow
);

    localparam int CH_W = $clog2(CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CH - 1);
    localparam logic signed [PSUM_W:0] Q_MAX = (PSUM_W+1)'(127);
    localparam logic signed [PSUM_W:0] Q_MIN = (PSUM_W+1)'(-128);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state_reg, state_next;
    logic [CH_W-1:0]           ch_reg, ch_next;
    logic                      overflow_reg;
    logic                      load, ovf_set, handshake, last_beat;

    logic signed [PSUM_W-1:0]  psum_reg [CH][POS];
    logic signed [BIAS_W-1:0]  bias_reg [CH];

    assign busy      = (state_reg == RUN);
    assign out_valid = busy;
    assign out_ch    = ch_reg;
    assign overflow  = overflow_reg;
    assign handshake = busy && out_ready;
    assign last_beat = (ch_reg == LAST_CH);

    // Next-state logic: capture, beat advance, end-of-layer and dropped-batch detection
    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        load       = 1'b0;
        ovf_set    = 1'b0;
        layer_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    ch_next    = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (handshake && last_beat) begin
                    // A reset in the same cycle discards the batch, so no completion pulse
                    layer_done = !rst_n;
                    ch_next    = '0;
                    if (in_valid) begin
                        // Back-to-back batch: restart at channel 0 without a bubble
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    if (handshake) begin
                        ch_next = ch_reg + 1'b1;
                    end
                    if (in_valid) begin
                        ovf_set = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg    <= IDLE;
            ch_reg       <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ch_reg    <= ch_next;
            if (ovf_set) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Batch storage: one bias and POS partial sums per channel, written only on capture
    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_store
            always_ff @(posedge clk) begin
                if (load) begin
                    bias_reg[gi] <= conv_bias[gi*BIAS_W +: BIAS_W];
                    for (int p = 0; p < POS; p++) begin
                        psum_reg[gi][p] <= output_conv[(gi*POS+p)*PSUM_W +: PSUM_W];
                    end
                end
            end
        end
    endgenerate

    // Per-position bias add, floor shift and saturation for the current channel
    generate
        for (genvar gi = 0; gi < POS; gi++) begin : g_pos
            logic signed [PSUM_W:0] sum;
            logic signed [PSUM_W:0] q;
            logic [7:0]             sat;

            // One extra bit keeps psum + bias from wrapping before the shift
            assign sum = {psum_reg[ch_reg][gi][PSUM_W-1], psum_reg[ch_reg][gi]}
                       + {{(PSUM_W+1-BIAS_W){bias_reg[ch_reg][BIAS_W-1]}}, bias_reg[ch_reg]};
            assign q   = sum >>> SHIFT;

            // Clamp to the 8-bit output range instead of truncating
            always_comb begin
                sat = q[7:0];
`ifdef CONV_BIAS_ACT_RELU_EN
                if (q[PSUM_W]) begin
                    sat = 8'd0;
                end else if (q > Q_MAX) begin
                    sat = 8'd127;
                end
`else
                if (q > Q_MAX) begin
                    sat = 8'h7F;
                end else if (q < Q_MIN) begin
                    sat = 8'h80;
                end
`endif
            end

            assign out_data[gi*8 +: 8] = busy ? sat : 8'd0;
        end
    endgenerate

endmodule

// File: tb/tb_conv_bias_act.sv
// Directed testbench for conv_bias_act: reset, basic streaming, sign/saturation
// corners, backpressure, overflow with back-to-back batches and mid-layer reset.
module tb_conv_bias_act;

    localparam int CH  = 32;
    localparam int POS = 4;
    localparam int PW  = 32;
    localparam int BW  = 16;
    localparam int SH  = 8;
    localparam int DW  = POS*CH*PW;
    localparam int BVW = CH*BW;

`ifdef CONV_BIAS_ACT_RELU_EN
    localparam logic [7:0] E_M5000 = 8'h00;
    localparam logic [7:0] E_M100K = 8'h00;
`else
    localparam logic [7:0] E_M5000 = 8'hEC;
    localparam logic [7:0] E_M100K = 8'h80;
`endif

    logic           clk = 1'b0;
    logic           rst_n, in_valid, out_ready;
    logic [DW-1:0]  output_conv;
    logic [BVW-1:0] conv_bias;
    logic           out_valid, layer_done, busy, overflow;
    logic [POS*8-1:0] out_data;
    logic [4:0]     out_ch;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0]  pa, pb;
    logic [BVW-1:0] ba, bb;

    conv_bias_act #(.CH(CH), .POS(POS), .PSUM_W(PW), .BIAS_W(BW), .SHIFT(SH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .output_conv(output_conv),
        .conv_bias(conv_bias), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_ch(out_ch), .layer_done(layer_done),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference requantization of one element
    function automatic logic [7:0] model_q(input longint ps, input longint b);
        longint q;
        q = (ps + b) >>> SH;
`ifdef CONV_BIAS_ACT_RELU_EN
        if (q < 0) q = 0;
        else if (q > 127) q = 127;
`else
        if (q > 127) q = 127;
        else if (q < -128) q = -128;
`endif
        return q[7:0];
    endfunction

    // Expected beat for channel c of a batch
    function automatic logic [POS*8-1:0] exp_beat(input logic [DW-1:0] pv, input logic [BVW-1:0] bv, input int c);
        logic [POS*8-1:0] r;
        logic signed [PW-1:0] ps;
        logic signed [BW-1:0] b;
        b = bv[c*BW +: BW];
        for (int p = 0; p < POS; p++) begin
            ps = pv[(c*POS+p)*PW +: PW];
            r[p*8 +: 8] = model_q(longint'(ps), longint'(b));
        end
        return r;
    endfunction

    // Deterministic batch covering in-range, positive and negative saturation
    task automatic make_batch(output logic [DW-1:0] pv, output logic [BVW-1:0] bv, input int seed);
        int v;
        for (int c = 0; c < CH; c++) begin
            for (int p = 0; p < POS; p++) begin
                v = (((c*131 + p*977 + seed*53) % 2000) - 1000) * 97;
                pv[(c*POS+p)*PW +: PW] = v;
            end
            v = ((c*41 + seed*7) % 600) - 300;
            bv[c*BW +: BW] = v[BW-1:0];
        end
    endtask

    // Present a batch for one cycle; returns at the cycle after capture
    task automatic load_batch(input logic [DW-1:0] pv, input logic [BVW-1:0] bv);
        @(posedge clk); #1;
        output_conv = pv;
        conv_bias   = bv;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        output_conv = '0; conv_bias = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        n_checks++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        n_checks++; if (out_ch !== 5'd0) begin n_fail++; $display("FAIL reset_out_ch got %0d exp 0", out_ch); end
        n_checks++; if (layer_done !== 1'b0) begin n_fail++; $display("FAIL reset_layer_done got %b exp 0", layer_done); end
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0;
        $display("reset: outputs idle after reset");
    endtask

    task automatic test_basic;
        make_batch(pa, ba, 1);
        pa[0 +: PW] = 32'd4096;
        ba[0 +: BW] = 16'd256;
        @(posedge clk); #1;
        output_conv = pa; conv_bias = ba; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pre_capture_valid got %b exp 0", out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0; output_conv = '0; conv_bias = '0;
        for (int b = 0; b < CH; b++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid beat %0d got %b exp 1", b, out_valid); end
            n_checks++; if (out_ch !== 5'(b)) begin n_fail++; $display("FAIL basic_ch beat %0d got %0d exp %0d", b, out_ch, b); end
            n_checks++; if (out_data !== exp_beat(pa, ba, b)) begin n_fail++; $display("FAIL basic_data beat %0d got %h exp %h", b, out_data, exp_beat(pa, ba, b)); end
            n_checks++; if (layer_done !== (b == CH-1)) begin n_fail++; $display("FAIL basic_layer_done beat %0d got %b exp %b", b, layer_done, b == CH-1); end
            if (b == 0) begin
                n_checks++; if (out_data[7:0] !== 8'd17) begin n_fail++; $display("FAIL basic_first_byte got %0d exp 17", out_data[7:0]); end
            end
            $display("basic: beat %0d ch %0d data %h done %b", b, out_ch, out_data, layer_done);
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_end_valid got %b exp 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_end_busy got %b exp 0", busy); end
    endtask

    task automatic test_signs;
        make_batch(pa, ba, 3);
        pa[0*PW +: PW] = -32'sd5000;
        pa[1*PW +: PW] = -32'sd100000;
        ba[0 +: BW]    = 16'd0;
        pa[(1*POS+0)*PW +: PW] = 32'd100000;
        ba[1*BW +: BW] = 16'h8000;
        load_batch(pa, ba);
        in_valid = 1'b0;
        for (int b = 0; b < CH; b++) begin
            @(negedge clk);
            n_checks++; if (out_data !== exp_beat(pa, ba, b)) begin n_fail++; $display("FAIL signs_data beat %0d got %h exp %h", b, out_data, exp_beat(pa, ba, b)); end
            if (b == 0) begin
                n_checks++; if (out_data[7:0] !== E_M5000) begin n_fail++; $display("FAIL signs_m5000 got %h exp %h", out_data[7:0], E_M5000); end
                n_checks++; if (out_data[15:8] !== E_M100K) begin n_fail++; $display("FAIL signs_m100000 got %h exp %h", out_data[15:8], E_M100K); end
            end
            if (b == 1) begin
                n_checks++; if (out_data[7:0] !== 8'd127) begin n_fail++; $display("FAIL signs_p100000 got %h exp 7f", out_data[7:0]); end
            end
            $display("signs: beat %0d ch %0d data %h", b, out_ch, out_data);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall;
        int exp_ch = 0;
        int stalls = 0;
        int beats  = 0;
        make_batch(pa, ba, 7);
        load_batch(pa, ba);
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 64 && beats < CH; cyc++) begin
            out_ready = !(exp_ch == 5 && stalls < 3);
            if (!out_ready) stalls++;
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid cyc %0d got %b exp 1", cyc, out_valid); end
            n_checks++; if (out_ch !== 5'(exp_ch)) begin n_fail++; $display("FAIL stall_ch cyc %0d got %0d exp %0d", cyc, out_ch, exp_ch); end
            n_checks++; if (out_data !== exp_beat(pa, ba, exp_ch)) begin n_fail++; $display("FAIL stall_data cyc %0d got %h exp %h", cyc, out_data, exp_beat(pa, ba, exp_ch)); end
            n_checks++; if (layer_done !== (out_ready && exp_ch == CH-1)) begin n_fail++; $display("FAIL stall_layer_done cyc %0d got %b exp %b", cyc, layer_done, out_ready && exp_ch == CH-1); end
            $display("stall: cyc %0d ch %0d ready %b data %h", cyc, out_ch, out_ready, out_data);
            if (out_ready) begin beats++; exp_ch++; end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        n_checks++; if (beats !== CH) begin n_fail++; $display("FAIL stall_beat_count got %0d exp %0d", beats, CH); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_end_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_overflow;
        make_batch(pa, ba, 11);
        make_batch(pb, bb, 19);
        load_batch(pa, ba);
        for (int b = 0; b < CH; b++) begin
            in_valid = (b == 10) || (b == CH-1);
            output_conv = pb; conv_bias = bb;
            @(negedge clk);
            n_checks++; if (out_ch !== 5'(b)) begin n_fail++; $display("FAIL ovf_a_ch beat %0d got %0d exp %0d", b, out_ch, b); end
            n_checks++; if (out_data !== exp_beat(pa, ba, b)) begin n_fail++; $display("FAIL ovf_a_data beat %0d got %h exp %h", b, out_data, exp_beat(pa, ba, b)); end
            n_checks++; if (layer_done !== (b == CH-1)) begin n_fail++; $display("FAIL ovf_a_layer_done beat %0d got %b exp %b", b, layer_done, b == CH-1); end
            if (b == 10 || b == 11) begin
                n_checks++; if (overflow !== (b == 11)) begin n_fail++; $display("FAIL ovf_flag beat %0d got %b exp %b", b, overflow, b == 11); end
            end
            $display("overflow A: beat %0d ch %0d data %h ovf %b done %b", b, out_ch, out_data, overflow, layer_done);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; output_conv = '0; conv_bias = '0;
        for (int b = 0; b < CH; b++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_b_valid beat %0d got %b exp 1", b, out_valid); end
            n_checks++; if (out_ch !== 5'(b)) begin n_fail++; $display("FAIL ovf_b_ch beat %0d got %0d exp %0d", b, out_ch, b); end
            n_checks++; if (out_data !== exp_beat(pb, bb, b)) begin n_fail++; $display("FAIL ovf_b_data beat %0d got %h exp %h", b, out_data, exp_beat(pb, bb, b)); end
            n_checks++; if (layer_done !== (b == CH-1)) begin n_fail++; $display("FAIL ovf_b_layer_done beat %0d got %b exp %b", b, layer_done, b == CH-1); end
            $display("overflow B: beat %0d ch %0d data %h done %b", b, out_ch, out_data, layer_done);
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_end_valid got %b exp 0", out_valid); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_reset_mid;
        make_batch(pa, ba, 23);
        make_batch(pb, bb, 29);
        load_batch(pa, ba);
        in_valid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            rst_n = (b == 7);
            @(negedge clk);
            n_checks++; if (out_ch !== 5'(b)) begin n_fail++; $display("FAIL rstmid_ch beat %0d got %0d exp %0d", b, out_ch, b); end
            n_checks++; if (out_data !== exp_beat(pa, ba, b)) begin n_fail++; $display("FAIL rstmid_data beat %0d got %h exp %h", b, out_data, exp_beat(pa, ba, b)); end
            n_checks++; if (layer_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_layer_done beat %0d got %b exp 0", b, layer_done); end
            $display("reset mid: beat %0d ch %0d rst %b data %h", b, out_ch, rst_n, out_data);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b exp 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        n_checks++; if (out_ch !== 5'd0) begin n_fail++; $display("FAIL rstmid_out_ch got %0d exp 0", out_ch); end
        n_checks++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_out_data got %h exp 0", out_data); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_overflow got %b exp 0", overflow); end
        load_batch(pb, bb);
        in_valid = 1'b0;
        for (int b = 0; b < CH; b++) begin
            @(negedge clk);
            n_checks++; if (out_ch !== 5'(b)) begin n_fail++; $display("FAIL restart_ch beat %0d got %0d exp %0d", b, out_ch, b); end
            n_checks++; if (out_data !== exp_beat(pb, bb, b)) begin n_fail++; $display("FAIL restart_data beat %0d got %h exp %h", b, out_data, exp_beat(pb, bb, b)); end
            n_checks++; if (layer_done !== (b == CH-1)) begin n_fail++; $display("FAIL restart_layer_done beat %0d got %b exp %b", b, layer_done, b == CH-1); end
            $display("restart: beat %0d ch %0d data %h done %b", b, out_ch, out_data, layer_done);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_signs;
        test_stall;
        test_overflow;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
